// File: rtl/processor_pkg.sv
// Shared definitions for the asm18 processor core: pipeline sequencer
// state encoding and the legal range for the pipeline depth.
package processor_pkg;

  typedef enum logic {
    PC_RUN  = 1'b0,
    PC_WAIT = 1'b1
  } pc_state_e;

  localparam int PC_STAGES_MIN = 2;
  localparam int PC_STAGES_MAX = 8;

endpackage

// File: rtl/pipeline_shift_chain.sv
// Per-stage valid/ip registers; shift one stage per enabled cycle, with a
// synchronous flush that kills every in-flight instruction.
module pipeline_shift_chain
  import processor_pkg::*;
#(
  parameter int ADDR_SIZE = 18,
  parameter int STAGES    = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        flush,
  input  logic [ADDR_SIZE-1:0]        in_ip,
  output logic [STAGES-1:0]           stage_valid,
  output logic [STAGES*ADDR_SIZE-1:0] stage_ip
);

  logic [STAGES-1:0]           valid_q, valid_d;
  logic [STAGES*ADDR_SIZE-1:0] ip_q, ip_d;

  // ip contents after a flush are don't-care, so they shift regardless
  always_comb begin
    valid_d = valid_q;
    ip_d    = ip_q;
    if (enable) begin
      ip_d    = {ip_q[(STAGES-1)*ADDR_SIZE-1:0], in_ip};
      valid_d = flush ? '0 : {valid_q[STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      ip_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ip_q    <= ip_d;
    end
  end

  assign stage_valid = valid_q;
  assign stage_ip    = ip_q;

endmodule

// File: rtl/pipeline_control.sv
// Pipeline sequencer for the staged asm18 core: fetch pointer, stage chain,
// branch flush, wait handshake, debug freeze, stall and retire counter.
module pipeline_control
  import processor_pkg::*;
#(
  parameter int                   ADDR_SIZE = 18,
  parameter int                   WORD_SIZE = 18,
  parameter int                   STAGES    = 3,
  parameter logic [ADDR_SIZE-1:0] RESET_IP  = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic [ADDR_SIZE-1:0]        code_addr,
  input  logic                        stall_in,
  input  logic                        branch_taken,
  input  logic [ADDR_SIZE-1:0]        branch_target,
  input  logic                        wait_hit,
  input  logic                        wait_continue_execution,
  input  logic                        debug_get_param,
  output logic                        advance,
  output logic [STAGES-1:0]           stage_valid,
  output logic [STAGES*ADDR_SIZE-1:0] stage_ip,
  output logic                        wait_for_continue,
  output logic                        debug_halted,
  output logic [WORD_SIZE-1:0]        retire_count
);

  if (STAGES < PC_STAGES_MIN || STAGES > PC_STAGES_MAX) begin : g_bad_stages
    $fatal(1, "pipeline_control: STAGES must be within 2..8");
  end

  pc_state_e              state_q, state_d;
  logic [ADDR_SIZE-1:0]   fetch_ip_q, fetch_ip_d;
  logic [WORD_SIZE-1:0]   retire_count_q, retire_count_d;
  logic                   debug_halted_q, debug_halted_d;
  logic                   wait_req;
  logic                   flush;
  logic                   advance_c;

  // A pending branch is kept live by the frozen last stage, so the flush
  // lands on whichever cycle advance finally rises.
  always_comb begin
    wait_req       = stage_valid[STAGES-1] & wait_hit;
    flush          = branch_taken & stage_valid[STAGES-1];
    advance_c      = 1'b0;
    state_d        = state_q;
    fetch_ip_d     = fetch_ip_q;
    retire_count_d = retire_count_q;
    debug_halted_d = debug_get_param;

    if (!stall_in && !debug_get_param) begin
      if (state_q == PC_RUN) begin
        advance_c = !(wait_req && !wait_continue_execution);
        if (wait_req && !wait_continue_execution) begin
          state_d = PC_WAIT;
        end
      end else begin
        advance_c = wait_continue_execution;
        if (wait_continue_execution) begin
          state_d = PC_RUN;
        end
      end
    end

    if (advance_c) begin
      fetch_ip_d = flush ? branch_target : fetch_ip_q + ADDR_SIZE'(1);
      if (stage_valid[STAGES-1]) begin
        retire_count_d = retire_count_q + WORD_SIZE'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= PC_RUN;
      fetch_ip_q     <= RESET_IP;
      retire_count_q <= '0;
      debug_halted_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_ip_q     <= fetch_ip_d;
      retire_count_q <= retire_count_d;
      debug_halted_q <= debug_halted_d;
    end
  end

  pipeline_shift_chain #(
    .ADDR_SIZE (ADDR_SIZE),
    .STAGES    (STAGES)
  ) u_chain (
    .clock       (clock),
    .reset       (reset),
    .enable      (advance_c),
    .flush       (flush),
    .in_ip       (fetch_ip_q),
    .stage_valid (stage_valid),
    .stage_ip    (stage_ip)
  );

  assign code_addr         = fetch_ip_q;
  assign advance           = advance_c;
  assign wait_for_continue = (state_q == PC_WAIT);
  assign debug_halted      = debug_halted_q;
  assign retire_count      = retire_count_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed scoreboard bench for pipeline_control at STAGES = 3, 2 and 8.
module tb_pipeline_control;

  localparam int A = 18;
  localparam int W = 18;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, reset2, reset8;
  logic         stallIn, branchTaken, branchTaken2, branchTaken8;
  logic [A-1:0] branchTarget;
  logic         waitHit, waitCont, debugGet;

  logic [A-1:0]   codeAddr, codeAddr2, codeAddr8;
  logic           adv, adv2, adv8;
  logic [2:0]     valid3;
  logic [1:0]     valid2;
  logic [7:0]     valid8;
  logic [3*A-1:0] ip3;
  logic [2*A-1:0] ip2;
  logic [8*A-1:0] ip8;
  logic           wfc, wfc2, wfc8;
  logic           dbgHalted, dbgHalted2, dbgHalted8;
  logic [W-1:0]   retired, retired2, retired8;

  pipeline_control #(.ADDR_SIZE(A), .WORD_SIZE(W), .STAGES(3), .RESET_IP(18'h10)) dut (
    .clock(clock), .reset(reset), .code_addr(codeAddr), .stall_in(stallIn),
    .branch_taken(branchTaken), .branch_target(branchTarget), .wait_hit(waitHit),
    .wait_continue_execution(waitCont), .debug_get_param(debugGet), .advance(adv),
    .stage_valid(valid3), .stage_ip(ip3), .wait_for_continue(wfc),
    .debug_halted(dbgHalted), .retire_count(retired));

  pipeline_control #(.ADDR_SIZE(A), .WORD_SIZE(W), .STAGES(2), .RESET_IP(18'h10)) dut2 (
    .clock(clock), .reset(reset2), .code_addr(codeAddr2), .stall_in(1'b0),
    .branch_taken(branchTaken2), .branch_target(branchTarget), .wait_hit(1'b0),
    .wait_continue_execution(1'b0), .debug_get_param(1'b0), .advance(adv2),
    .stage_valid(valid2), .stage_ip(ip2), .wait_for_continue(wfc2),
    .debug_halted(dbgHalted2), .retire_count(retired2));

  pipeline_control #(.ADDR_SIZE(A), .WORD_SIZE(W), .STAGES(8), .RESET_IP(18'h10)) dut8 (
    .clock(clock), .reset(reset8), .code_addr(codeAddr8), .stall_in(1'b0),
    .branch_taken(branchTaken8), .branch_target(branchTarget), .wait_hit(1'b0),
    .wait_continue_execution(1'b0), .debug_get_param(1'b0), .advance(adv8),
    .stage_valid(valid8), .stage_ip(ip8), .wait_for_continue(wfc8),
    .debug_halted(dbgHalted8), .retire_count(retired8));

  logic [63:0] expectQ[$];
  int vectorCount = 0;
  int failCount   = 0;

  // Queue an expected value; it is consumed in order by checkOutput.
  task automatic pushExpected(input logic [63:0] value);
    expectQ.push_back(value);
  endtask

  // Pop the oldest expectation and compare it with the observed DUT value.
  task automatic checkOutput(input string tag, input logic [63:0] observed);
    logic [63:0] expected;
    vectorCount++;
    if (expectQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=<empty scoreboard>", tag, observed);
    end else begin
      expected = expectQ.pop_front();
      assert (observed === expected) else begin
        failCount++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1; reset8 = 1'b1;
    stallIn = 1'b0; branchTaken = 1'b0; branchTaken2 = 1'b0; branchTaken8 = 1'b0;
    branchTarget = '0; waitHit = 1'b0; waitCont = 1'b0; debugGet = 1'b0;
    #2;

    // Reset values
    pushExpected(18'h10); pushExpected(0); pushExpected(0);
    pushExpected(0); pushExpected(0); pushExpected(1); pushExpected(0);
    checkOutput("rst_code", codeAddr);
    checkOutput("rst_valid", valid3);
    checkOutput("rst_retire", retired);
    checkOutput("rst_wfc", wfc);
    checkOutput("rst_dbg", dbgHalted);
    checkOutput("rst_adv", adv);
    checkOutput("rst_ip", ip3);

    @(negedge clock);
    reset = 1'b0;

    // Fill: edges 1..3
    for (int k = 1; k <= 3; k++) begin
      applyStimulus();
      pushExpected(18'h10 + k);
      pushExpected((1 << k) - 1);
      checkOutput("fill_code", codeAddr);
      checkOutput("fill_valid", valid3);
    end
    pushExpected(18'h10); pushExpected(0);
    checkOutput("fill_last_ip", ip3[2*A +: A]);
    checkOutput("fill_retire", retired);

    applyStimulus();
    pushExpected(1); pushExpected(18'h11);
    checkOutput("first_retire", retired);
    checkOutput("e4_last_ip", ip3[2*A +: A]);

    // Branch at 0x12 to 0x100
    applyStimulus();
    pushExpected(18'h12); pushExpected(2);
    checkOutput("br_last_ip", ip3[2*A +: A]);
    checkOutput("br_retire_pre", retired);
    branchTaken = 1'b1; branchTarget = 18'h100;
    applyStimulus();
    branchTaken = 1'b0;
    pushExpected(0); pushExpected(18'h100); pushExpected(3);
    checkOutput("br_flush_valid", valid3);
    checkOutput("br_code", codeAddr);
    checkOutput("br_retire", retired);
    for (int k = 1; k <= 2; k++) begin
      applyStimulus();
      pushExpected(0);
      checkOutput("br_bubble_last", valid3[2]);
    end
    applyStimulus();
    pushExpected(3'b111); pushExpected(18'h100); pushExpected(3);
    checkOutput("br_refill_valid", valid3);
    checkOutput("br_target_last", ip3[2*A +: A]);
    checkOutput("br_retire_hold", retired);

    // Wait with continue low, pulse 5 cycles later
    waitHit = 1'b1;
    #1;
    pushExpected(0); pushExpected(0);
    checkOutput("wait_adv_now", adv);
    checkOutput("wait_wfc_now", wfc);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus();
      pushExpected(1); pushExpected(18'h103); pushExpected(0); pushExpected(3);
      checkOutput("wait_wfc", wfc);
      checkOutput("wait_code_hold", codeAddr);
      checkOutput("wait_adv", adv);
      checkOutput("wait_retire", retired);
    end
    waitCont = 1'b1;
    #1;
    pushExpected(1);
    checkOutput("cont_pulse_adv", adv);
    applyStimulus();
    waitCont = 1'b0; waitHit = 1'b0;
    #1;
    pushExpected(0); pushExpected(4); pushExpected(18'h101); pushExpected(18'h104); pushExpected(1);
    checkOutput("cont_wfc", wfc);
    checkOutput("cont_retire", retired);
    checkOutput("cont_last_ip", ip3[2*A +: A]);
    checkOutput("cont_code", codeAddr);
    checkOutput("cont_adv_after", adv);

    // Continue held high across waits
    waitCont = 1'b1; waitHit = 1'b1;
    #1;
    pushExpected(1);
    checkOutput("held_adv", adv);
    for (int k = 1; k <= 2; k++) begin
      applyStimulus();
      pushExpected(0); pushExpected(4 + k); pushExpected(18'h101 + k);
      checkOutput("held_wfc", wfc);
      checkOutput("held_retire", retired);
      checkOutput("held_last_ip", ip3[2*A +: A]);
    end

    // Debug freeze during WAIT with a swallowed continue pulse
    waitCont = 1'b0;
    #1;
    pushExpected(0);
    checkOutput("dbg_wait_adv", adv);
    applyStimulus();
    pushExpected(1);
    checkOutput("dbg_enter_wait", wfc);
    debugGet = 1'b1;
    applyStimulus();
    pushExpected(1); pushExpected(1);
    checkOutput("dbg_halted_lag", dbgHalted);
    checkOutput("dbg_wfc", wfc);
    waitCont = 1'b1;
    #1;
    pushExpected(0);
    checkOutput("dbg_cont_ignored", adv);
    applyStimulus();
    waitCont = 1'b0;
    pushExpected(1); pushExpected(6);
    checkOutput("dbg_still_wait", wfc);
    checkOutput("dbg_retire", retired);
    applyStimulus();
    applyStimulus();
    pushExpected(1);
    checkOutput("dbg_halted_hold", dbgHalted);
    debugGet = 1'b0;
    #1;
    pushExpected(1); pushExpected(0);
    checkOutput("dbg_release_lag", dbgHalted);
    checkOutput("dbg_release_adv", adv);
    applyStimulus();
    pushExpected(0); pushExpected(1); pushExpected(6); pushExpected(18'h106);
    checkOutput("dbg_halted_clear", dbgHalted);
    checkOutput("dbg_resume_wait", wfc);
    checkOutput("dbg_retire_hold", retired);
    checkOutput("dbg_code_hold", codeAddr);
    waitCont = 1'b1;
    #1;
    pushExpected(1);
    checkOutput("dbg_cont_adv", adv);
    applyStimulus();
    waitCont = 1'b0; waitHit = 1'b0;
    pushExpected(0); pushExpected(7); pushExpected(18'h104);
    checkOutput("dbg_exit_wfc", wfc);
    checkOutput("dbg_exit_retire", retired);
    checkOutput("dbg_exit_last_ip", ip3[2*A +: A]);

    // Stall during branch retire delays the flush
    branchTaken = 1'b1; branchTarget = 18'h200; stallIn = 1'b1;
    #1;
    pushExpected(0);
    checkOutput("stall_adv", adv);
    for (int k = 1; k <= 2; k++) begin
      applyStimulus();
      pushExpected(3'b111); pushExpected(18'h107); pushExpected(7);
      checkOutput("stall_valid", valid3);
      checkOutput("stall_code", codeAddr);
      checkOutput("stall_retire", retired);
    end
    stallIn = 1'b0;
    #1;
    pushExpected(1);
    checkOutput("unstall_adv", adv);
    applyStimulus();
    branchTaken = 1'b0;
    pushExpected(0); pushExpected(18'h200); pushExpected(8);
    checkOutput("stall_flush_valid", valid3);
    checkOutput("stall_flush_code", codeAddr);
    checkOutput("stall_flush_retire", retired);

    // Async reset mid-cycle in WAIT with a full pipeline
    for (int k = 1; k <= 3; k++) applyStimulus();
    pushExpected(3'b111);
    checkOutput("full_valid", valid3);
    waitHit = 1'b1;
    applyStimulus();
    pushExpected(1);
    checkOutput("pre_reset_wfc", wfc);
    #2;
    reset = 1'b1;
    #1;
    pushExpected(18'h10); pushExpected(0); pushExpected(0);
    pushExpected(0); pushExpected(0); pushExpected(0);
    checkOutput("async_code", codeAddr);
    checkOutput("async_valid", valid3);
    checkOutput("async_ip", ip3);
    checkOutput("async_wfc", wfc);
    checkOutput("async_retire", retired);
    checkOutput("async_dbg", dbgHalted);
    waitHit = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // STAGES = 2: fill then branch at 0x12
    @(negedge clock);
    reset2 = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      applyStimulus();
      pushExpected(18'h10 + k); pushExpected((1 << k) - 1);
      checkOutput("s2_fill_code", codeAddr2);
      checkOutput("s2_fill_valid", valid2);
    end
    applyStimulus();
    applyStimulus();
    pushExpected(18'h12); pushExpected(2);
    checkOutput("s2_last_ip", ip2[A +: A]);
    checkOutput("s2_retire", retired2);
    branchTaken2 = 1'b1; branchTarget = 18'h100;
    applyStimulus();
    branchTaken2 = 1'b0;
    pushExpected(0); pushExpected(18'h100); pushExpected(3);
    checkOutput("s2_flush_valid", valid2);
    checkOutput("s2_br_code", codeAddr2);
    checkOutput("s2_br_retire", retired2);
    applyStimulus();
    pushExpected(0);
    checkOutput("s2_bubble_last", valid2[1]);
    applyStimulus();
    pushExpected(2'b11); pushExpected(18'h100);
    checkOutput("s2_refill_valid", valid2);
    checkOutput("s2_target_last", ip2[A +: A]);

    // STAGES = 8: fill then branch at 0x12
    @(negedge clock);
    reset8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus();
      pushExpected(18'h10 + k); pushExpected((1 << k) - 1);
      checkOutput("s8_fill_code", codeAddr8);
      checkOutput("s8_fill_valid", valid8);
    end
    pushExpected(18'h10);
    checkOutput("s8_first_last_ip", ip8[7*A +: A]);
    applyStimulus();
    applyStimulus();
    pushExpected(18'h12); pushExpected(2);
    checkOutput("s8_last_ip", ip8[7*A +: A]);
    checkOutput("s8_retire", retired8);
    branchTaken8 = 1'b1; branchTarget = 18'h100;
    applyStimulus();
    branchTaken8 = 1'b0;
    pushExpected(0); pushExpected(18'h100); pushExpected(3);
    checkOutput("s8_flush_valid", valid8);
    checkOutput("s8_br_code", codeAddr8);
    checkOutput("s8_br_retire", retired8);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus();
      pushExpected(0);
      checkOutput("s8_bubble_last", valid8[7]);
    end
    applyStimulus();
    pushExpected(8'hFF); pushExpected(18'h100); pushExpected(3);
    checkOutput("s8_refill_valid", valid8);
    checkOutput("s8_target_last", ip8[7*A +: A]);
    checkOutput("s8_retire_hold", retired8);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Parametrised pipeline sequencer for the staged asm18 processor core. It owns the fetch instruction pointer and the per-stage valid/ip shift chain for a pipeline of `STAGES` stages, and applies flush on taken branches/calls. It implements the `wait` halt/continue handshake, a debug freeze, an external stall and a retired-instruction counter. It replaces the hand-wired fetch/no_operation plumbing in the processor top, so stage modules only consume `stage_valid`/`stage_ip` and `advance`.

## Interface
Parameters:
- `ADDR_SIZE`, 18, width of instruction addresses.
- `WORD_SIZE`, 18, width of `retire_count`.
- `STAGES`, 3, number of pipeline stages after fetch address issue; legal range 2..8.
- `RESET_IP`, 0, fetch address after reset.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `code_addr`  out  ADDR_SIZE  fetch address to synchronous code memory (word returns next cycle).
- `stall_in`  in  1  external hold (memory busy); freezes pipeline while high.
- `branch_taken`  in  1  last stage resolves a taken jump/call; honoured only when `stage_valid[STAGES-1]`.
- `branch_target`  in  ADDR_SIZE  new fetch address for `branch_taken`.
- `wait_hit`  in  1  last stage holds a valid `wait` instruction.
- `wait_continue_execution`  in  1  1-cycle continue pulse, or held high to run through waits.
- `debug_get_param`  in  1  debug freeze request.
- `advance`  out  1  stage registers capture this cycle.
- `stage_valid`  out  STAGES  bit k = stage k holds a real instruction (inverse of no_operation).
- `stage_ip`  out  STAGES*ADDR_SIZE  ip of stage k in bits [k*ADDR_SIZE +: ADDR_SIZE].
- `wait_for_continue`  out  1  FSM in WAIT.
- `debug_halted`  out  1  registered; pipeline frozen, register file safe to read.
- `retire_count`  out  WORD_SIZE  instructions retired from last stage, wraps modulo 2^WORD_SIZE.

## Operation
- FSM states: RUN, WAIT. Reset -> RUN.
- `wait_req = stage_valid[STAGES-1] & wait_hit`.
- `advance` is combinational and high when all of the following hold:
  - `!stall_in`
  - `!debug_get_param`
  - either (RUN and !(wait_req & !wait_continue_execution)) or (WAIT and `wait_continue_execution`).
- FSM transitions:
  - RUN -> WAIT: `wait_req & !wait_continue_execution & !stall_in & !debug_get_param`.
  - WAIT -> RUN: on the cycle `advance` is high (the wait instruction retires).
  - `wait_continue_execution` is ignored while `stall_in` or `debug_get_param` is high; the FSM stays in WAIT.
- On `advance` without branch:
  - `stage_ip[0] <= fetch_ip`, `stage_valid[0] <= 1`.
  - Stage k gets stage k-1.
  - `fetch_ip <= fetch_ip + 1`, wrapping modulo 2^ADDR_SIZE.
- On `advance` with `branch_taken & stage_valid[STAGES-1]`:
  - All `stage_valid` bits <= 0.
  - `fetch_ip <= branch_target`.
  - `stage_ip` contents are don't-care.
  - The branching instruction itself retires.
- `branch_taken` without a valid last stage is ignored.
- If `branch_taken` arrives while frozen, the flush is applied on the first cycle `advance` rises.
- `retire_count` increments on `advance & stage_valid[STAGES-1]`.
- `code_addr = fetch_ip` combinationally. While `advance` is low, fetch_ip holds and the same word is re-read.
- `debug_halted <= debug_get_param`, one-cycle delay.
- Reset values: fetch_ip=RESET_IP, stage_valid=0, stage_ip=0, state RUN, retire_count=0, debug_halted=0.
  - Hence after reset `code_addr`=RESET_IP, `wait_for_continue`=0.
- Reset mid-operation: async clear, no in-flight instruction retires.

## Timing
- Fetch-to-last-stage latency: STAGES cycles with no stalls. An address issued in cycle n is valid in stage 0 at n+1 and in stage STAGES-1 at n+STAGES.
- Taken-branch penalty: target becomes `code_addr` the cycle after the branch retires. First target instruction reaches the last stage STAGES cycles after that; STAGES bubbles in total.
- WAIT entry takes effect the same cycle: `advance`=0 immediately on `wait_req`, and `wait_for_continue`=1 from the next cycle.
- Continue is combinational to `advance` in the pulse cycle.
- Held-high `wait_continue_execution`: wait retires with zero stall and `wait_for_continue` never asserts.
- Debug freeze acts in the same cycle (`advance`=0); `debug_halted` follows one cycle later. Release resumes the previous FSM state.

## Structure
- Shared package `processor_pkg`: FSM state enum (`PC_RUN`, `PC_WAIT`) and the STAGES range check constants (`PC_STAGES_MIN`=2, `PC_STAGES_MAX`=8).
- Parameter elaboration check: STAGES outside 2..8 is a fatal elaboration error.
- One sub-module: `pipeline_shift_chain` (STAGES × {valid, ip} registers with enable and synchronous flush). The FSM, fetch_ip and counter stay in `pipeline_control`.

## Test plan
- Reset release, STAGES=3, RESET_IP=0x10, no stimulus:
  - `code_addr` 0x10, 0x11, 0x12 on consecutive cycles.
  - `stage_valid` goes 001, 011, 111.
  - `retire_count`=1 on the cycle after stage 2 first holds ip 0x10.
- Branch at ip 0x12, target 0x100:
  - All `stage_valid`=0 next cycle and `code_addr`=0x100.
  - 0x100 reaches stage 2 exactly 3 cycles later.
  - `retire_count` counts the branch.
- Wait with continue low:
  - Freeze; `wait_for_continue`=1 from the next cycle.
  - 1-cycle continue pulse 5 cycles later -> `advance`=1 in that cycle only, FSM RUN.
  - Counter +1 for the wait.
- Continue held high across a wait instruction -> no freeze, `wait_for_continue` stays 0.
- Debug and stall:
  - `debug_get_param` for 4 cycles during WAIT, with a continue pulse inside it -> pulse ignored, `debug_halted` lags by 1, FSM remains WAIT.
  - `stall_in` during branch retire -> flush delayed until stall drops.
- Async reset asserted mid-cycle while in WAIT with a full pipeline -> all outputs at reset values before the next edge.
- Repeat the reset and branch scenarios at STAGES=2 and STAGES=8.
